// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: the add/subtract mode encoding used by the
// add/sub datapath and its bus interface.
package arith_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

endpackage

// File: rtl/add_sub_unit_if.sv
// Operand/result bundle for add_sub_unit; the master issues operations and the
// slave (the unit) returns registered results.
interface add_sub_unit_if #(
  parameter int WIDTH = 1
);
  import arith_pkg::*;

  logic             in_valid;
  mode_t            mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic             y;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid, mode, a, b, cin,
    input  x, y, ovf, out_valid
  );

  modport slave (
    input  in_valid, mode, a, b, cin,
    output x, y, ovf, out_valid
  );

endinterface

// File: rtl/add_sub_unit_full_add_cell.sv
// One-bit combinational full adder, the building block of the ripple chain.
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/add_sub_unit.sv
// Registered ripple-carry adder/subtractor with carry/borrow in/out and signed
// overflow; results appear one cycle after a valid operand capture.
module add_sub_unit
  import arith_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  add_sub_unit_if.slave bus
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic             is_sub;

  logic [WIDTH-1:0] x_d, x_q;
  logic             y_d, y_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  // Subtraction runs as a + ~b + ~cin so one adder chain serves both modes.
  assign is_sub   = (bus.mode == MODE_SUB);
  assign b_eff    = is_sub ? ~bus.b : bus.b;
  assign carry[0] = is_sub ? ~bus.cin : bus.cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    full_add_cell u_cell (
      .a  (bus.a[gi]),
      .b  (b_eff[gi]),
      .ci (carry[gi]),
      .s  (sum[gi]),
      .co (carry[gi+1])
    );
  end

  // Held outputs only ever reload from the chain on a valid cycle, so X on idle
  // operands cannot leak into them.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      x_d   = sum;
      y_d   = is_sub ? ~carry[WIDTH] : carry[WIDTH];
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_add_sub_unit.sv
// Scoreboard bench for add_sub_unit at WIDTH=1 and WIDTH=8: drivers queue the
// hand-computed results, monitors pop and compare whenever out_valid is seen.
module tb_add_sub_unit;
  import arith_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  add_sub_unit_if #(.WIDTH(1)) if1 ();
  add_sub_unit_if #(.WIDTH(8)) if8 ();

  add_sub_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  add_sub_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  // Expected responses packed as {x, y, ovf}.
  logic [2:0] q1[$];
  logic [9:0] q8[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic issue1(input mode_t m, input logic a, input logic b, input logic c,
                        input logic ex, input logic ey, input logic eo);
    @(posedge clk); #1;
    if1.in_valid = 1'b1; if1.mode = m; if1.a = a; if1.b = b; if1.cin = c;
    q1.push_back({ex, ey, eo});
    $display("w1 issue mode=%0d a=%0b b=%0b cin=%0b -> x=%0b y=%0b ovf=%0b", m, a, b, c, ex, ey, eo);
  endtask

  task automatic issue8(input mode_t m, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] ex, input logic ey, input logic eo);
    @(posedge clk); #1;
    if8.in_valid = 1'b1; if8.mode = m; if8.a = a; if8.b = b; if8.cin = c;
    q8.push_back({ex, ey, eo});
    $display("w8 issue mode=%0d a=%02h b=%02h cin=%0b -> x=%02h y=%0b ovf=%0b", m, a, b, c, ex, ey, eo);
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    if1.in_valid = 1'b0;
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  initial begin : mon1
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (if1.out_valid === 1'b1) begin
        if (q1.size() == 0) begin
          check("w1_unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = q1.pop_front();
          check("w1_x", 64'(if1.x), 64'(e[2]));
          check("w1_y", 64'(if1.y), 64'(e[1]));
          check("w1_ovf", 64'(if1.ovf), 64'(e[0]));
          $display("w1 result x=%0b y=%0b ovf=%0b", if1.x, if1.y, if1.ovf);
        end
      end
    end
  end

  initial begin : mon8
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (if8.out_valid === 1'b1) begin
        if (q8.size() == 0) begin
          check("w8_unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = q8.pop_front();
          check("w8_x", 64'(if8.x), 64'(e[9:2]));
          check("w8_y", 64'(if8.y), 64'(e[1]));
          check("w8_ovf", 64'(if8.ovf), 64'(e[0]));
          $display("w8 result x=%02h y=%0b ovf=%0b", if8.x, if8.y, if8.ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0] add_xy [8];
    logic [1:0] sub_xy [8];
    logic       add_ov [8];
    logic       sub_ov [8];
    logic [2:0] combo;

    add_xy = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    sub_xy = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    add_ov = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sub_ov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    if1.in_valid = 1'b0; if1.mode = MODE_ADD; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    if8.in_valid = 1'b0; if8.mode = MODE_ADD; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_w1_x", 64'(if1.x), 64'd0);
    check("rst_w1_valid", 64'(if1.out_valid), 64'd0);
    check("rst_w8_x", 64'(if8.x), 64'd0);
    check("rst_w8_y", 64'(if8.y), 64'd0);
    check("rst_w8_ovf", 64'(if8.ovf), 64'd0);
    check("rst_w8_valid", 64'(if8.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // WIDTH=1 exhaustive truth tables, one operation per 10-cycle window.
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      issue1(MODE_ADD, combo[2], combo[1], combo[0], add_xy[i][1], add_xy[i][0], add_ov[i]);
      idle1();
      repeat (8) @(posedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i);
      issue1(MODE_SUB, combo[2], combo[1], combo[0], sub_xy[i][1], sub_xy[i][0], sub_ov[i]);
      idle1();
      repeat (8) @(posedge clk);
    end

    // WIDTH=8 directed vectors, issued back to back.
    issue8(MODE_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    issue8(MODE_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    issue8(MODE_ADD, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    issue8(MODE_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    issue8(MODE_SUB, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    issue8(MODE_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    issue8(MODE_SUB, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
    issue8(MODE_SUB, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
    idle8();
    repeat (3) @(posedge clk);

    // Single valid pulse, then idle with random and unknown operands.
    issue8(MODE_ADD, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
    idle8();
    for (int k = 0; k < 4; k++) begin
      if8.mode = mode_t'($urandom_range(0, 1));
      if8.a    = (k == 3) ? 8'hxx : 8'($urandom);
      if8.b    = 8'($urandom);
      if8.cin  = 1'($urandom);
      @(posedge clk); #2;
      check("hold_valid_low", 64'(if8.out_valid), 64'd0);
      check("hold_x", 64'(if8.x), 64'h77);
      check("hold_y", 64'(if8.y), 64'd0);
    end

    // Asynchronous reset while a result is being presented.
    issue8(MODE_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    @(posedge clk); #1;
    if8.a = 8'h55; if8.b = 8'hAA; if8.cin = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", 64'(if8.x), 64'd0);
    check("async_rst_y", 64'(if8.y), 64'd0);
    check("async_rst_ovf", 64'(if8.ovf), 64'd0);
    check("async_rst_valid", 64'(if8.out_valid), 64'd0);
    @(posedge clk); #2;
    check("in_rst_x", 64'(if8.x), 64'd0);
    check("in_rst_valid", 64'(if8.out_valid), 64'd0);
    if8.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    check("post_rst_x", 64'(if8.x), 64'd0);
    check("post_rst_valid", 64'(if8.out_valid), 64'd0);
    issue8(MODE_SUB, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0);
    idle8();
    repeat (3) @(posedge clk);

    check("w1_queue_drained", 64'(q1.size()), 64'd0);
    check("w8_queue_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
